// File: rtl/acc_exec_unit.sv
// Accumulator execute stage: drives an external chained-bitslice ALU and
// writes its result back into the accumulator and the C/Z flags.
module acc_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] out_alu_a,
  output logic [WIDTH-1:0] out_alu_b,
  output logic             out_alu_carry,
  output logic [2:0]       out_alu_control,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic             in_alu_carry,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry_flag,
  output logic             out_zero_flag,
  output logic             out_done,
  output logic             out_store_valid,
  output logic [WIDTH-1:0] out_store_data,
  output logic             out_illegal
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_STA  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADC  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_ORN  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_ANDN = 4'b1001;
  localparam logic [3:0] OP_NOTA = 4'b1010;
  localparam logic [3:0] OP_NOTB = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_opcode;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_z;

  logic             w_is_alu;
  logic             w_is_arith;
  logic [2:0]       w_ctrl;
  logic             w_cin;
  logic             w_accept;
  logic             w_exec;

  // Opcode decode into ALU control/carry-in; arith ops are the only ones
  // allowed to update the carry flag.
  always_comb begin
    w_is_alu   = 1'b0;
    w_is_arith = 1'b0;
    w_ctrl     = 3'b000;
    w_cin      = 1'b0;
    case (r_opcode)
      OP_ADD:  begin w_is_alu = 1'b1; w_is_arith = 1'b1; w_ctrl = 3'b000; end
      OP_ADC:  begin w_is_alu = 1'b1; w_is_arith = 1'b1; w_ctrl = 3'b000; w_cin = r_c; end
      OP_SUB:  begin w_is_alu = 1'b1; w_is_arith = 1'b1; w_ctrl = 3'b001; w_cin = 1'b1; end
      OP_OR:   begin w_is_alu = 1'b1; w_ctrl = 3'b010; end
      OP_ORN:  begin w_is_alu = 1'b1; w_ctrl = 3'b011; end
      OP_AND:  begin w_is_alu = 1'b1; w_ctrl = 3'b100; end
      OP_ANDN: begin w_is_alu = 1'b1; w_ctrl = 3'b101; end
      OP_NOTA: begin w_is_alu = 1'b1; w_ctrl = 3'b110; end
      OP_NOTB: begin w_is_alu = 1'b1; w_ctrl = 3'b111; end
      default: ;
    endcase
  end

  assign w_exec   = (r_state == S_EXEC);
  assign w_accept = in_valid && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= OP_NOP;
      r_operand <= '0;
      r_acc     <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opcode  <= in_opcode;
        r_operand <= in_operand;
      end
      // Write-back happens on the single EXEC cycle.
      if (w_exec) begin
        if (r_opcode == OP_LDA) begin
          r_acc <= r_operand;
          r_z   <= (r_operand == '0);
        end else if (w_is_alu) begin
          r_acc <= in_alu_result;
          r_z   <= (in_alu_result == '0);
          if (w_is_arith) r_c <= in_alu_carry;
        end
      end
    end
  end

  assign out_ready       = (r_state == S_IDLE);
  assign out_done        = (r_state == S_DONE);
  assign out_store_valid = (r_state == S_DONE) && (r_opcode == OP_STA);
  assign out_illegal     = (r_state == S_DONE) && (r_opcode[3:2] == 2'b11);
  assign out_store_data  = r_acc;
  assign out_acc         = r_acc;
  assign out_carry_flag  = r_c;
  assign out_zero_flag   = r_z;

  assign out_alu_a       = r_acc;
  assign out_alu_b       = w_exec ? r_operand : '0;
  assign out_alu_control = w_exec ? w_ctrl : 3'b000;
  assign out_alu_carry   = w_exec ? w_cin : 1'b0;

endmodule

// File: doc/acc_exec_unit.md
Name: acc_exec_unit

Overview:
- Accumulator execute stage that sits directly upstream of the WIDTH-bit ALU built from chained alu_bitslice instances, and consumes that ALU's result.
- Accepts one decoded instruction (opcode + operand) per handshake and drives the ALU's A, B, carry-in and 3-bit control.
- Captures the ALU result into the accumulator and updates the carry and zero flags.
- Signals completion, and requests a store for STA.

Parameters:
WIDTH, 8, datapath width; equals the number of bitslices in the ALU.

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction valid from decode
out_ready  output  1  unit can accept an instruction
in_opcode  input  4  instruction opcode
in_operand  input  WIDTH  memory/immediate operand
out_alu_a  output  WIDTH  ALU A input (accumulator)
out_alu_b  output  WIDTH  ALU B input
out_alu_carry  output  1  carry-in to slice 0
out_alu_control  output  3  ALU control code
in_alu_result  input  WIDTH  ALU result
in_alu_carry  input  1  carry-out of MSB slice
out_acc  output  WIDTH  accumulator
out_carry_flag  output  1  C flag
out_zero_flag  output  1  Z flag
out_done  output  1  one-cycle completion pulse
out_store_valid  output  1  one-cycle store request
out_store_data  output  WIDTH  store data
out_illegal  output  1  one-cycle illegal-opcode pulse

Behaviour:
- Reset (async, in_rst_n=0): state IDLE; acc, op/operand registers, C, Z = 0. out_ready=1; done/store_valid/illegal=0. Reset mid-instruction drops it: no done/store/illegal pulse is produced.
- FSM states IDLE, EXEC, DONE.
  - IDLE: out_ready=1. On in_valid&out_ready at edge E0: latch opcode/operand, go to EXEC.
  - EXEC: out_ready=0, ALU driven from the latched registers. At edge E1: write back, go to DONE.
  - DONE: out_ready=0, out_done=1. At edge E2: go to IDLE.
- Throughput: one instruction per 3 cycles. in_valid is ignored while out_ready=0; upstream must hold the instruction.
- ALU drive:
  - out_alu_a = acc at all times.
  - In EXEC: out_alu_b = operand register; control and carry-in are decoded from the opcode.
  - In IDLE and DONE: b=0, control=000, carry=0.
- Opcodes, as (ALU control, carry-in):
  - 0000 NOP: no change.
  - 0001 LDA: acc<=operand, bypasses the ALU.
  - 0010 STA: acc unchanged; in DONE out_store_valid=1 and out_store_data=acc.
  - 0011 ADD: (000, 0).
  - 0100 ADC: (000, C).
  - 0101 SUB: (001, 1).
  - 0110 OR: (010, 0).
  - 0111 ORN: (011, 0).
  - 1000 AND: (100, 0).
  - 1001 ANDN: (101, 0).
  - 1010 NOTA: (110, 0).
  - 1011 NOTB: (111, 0).
  - 1100-1111 illegal: no state change; out_illegal=1 in DONE, and out_done is still asserted.
- Write-back at E1:
  - ALU ops (0011-1011): acc<=in_alu_result.
  - LDA: acc<=operand.
- Flags:
  - C <= in_alu_carry for ADD/ADC/SUB only; unchanged otherwise. For SUB, C=1 means no borrow.
  - Z <= (new acc==0) for LDA and all ALU ops; unchanged for NOP/STA/illegal.
- Arithmetic wraps modulo 2^WIDTH; carry-out is taken only from in_alu_carry.
- out_store_data = acc continuously; it is qualified only by out_store_valid.
- All outputs are registered or decoded from state/registers; there is no combinational path from in_valid to out_ready.

Test Plan:
- Add with/without carry-out: reset, LDA 0x7F, ADD 0x01 -> acc=0x80, C=0, Z=0. Then LDA 0xFF, ADD 0x01 -> acc=0x00, C=1, Z=1. Then ADC 0x00 -> acc=0x01, C=0, Z=0.
- Subtract: LDA 0x05, SUB 0x05 -> acc=0x00, C=1, Z=1. LDA 0x05, SUB 0x06 -> acc=0xFF, C=0, Z=0.
- Logic ops (C must stay unchanged throughout): LDA 0xF0, AND 0x3C -> 0x30. ANDN 0x3C -> 0x00, Z=1. NOTA -> 0xFF. ORN 0xFF -> 0xFF. NOTB 0x0F -> 0xF0.
- Handshake timing: hold in_valid high with back-to-back instructions.
  - out_ready low exactly 2 cycles per accept.
  - out_done high one cycle at E1+1.
  - Instruction held during busy is accepted exactly once.
- STA/illegal: LDA 0xA5, STA -> single out_store_valid pulse with data 0xA5, acc/flags unchanged. Opcode 0xE -> out_illegal and out_done for 1 cycle, acc/flags unchanged.
- Reset mid-op: accept ADD 0x01 with acc=0x10, pull in_rst_n low during EXEC -> immediately acc=0, C=Z=0, out_ready=1. No done/store pulse afterwards.
